// File: rtl/mux_scan_pkg.sv
// Shared types and default constants for the mux scan controller.
package mux_scan_pkg;

  // Scan controller states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_OUTPUT = 2'd3
  } scan_state_e;

  // Default number of mux inputs, select width and settle cycles per channel.
  localparam int N_DEF     = 16;
  localparam int SEL_W_DEF = 4;
  localparam int DWELL_DEF = 2;

endpackage

// File: rtl/mux_scan_dwell_cnt.sv
// Settle-time counter: counts edges spent on one channel and flags the last one.
module mux_scan_dwell_cnt
  import mux_scan_pkg::*;
#(
  parameter int DWELL = DWELL_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [7:0] CNT_LAST = 8'(DWELL - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // Next count: clear has priority, otherwise advance while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = 8'd0;
    end else if (en) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register, cleared asynchronously on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Terminal count marks the final settle edge of the current channel.
  assign tc = en & (cnt_q == CNT_LAST);

endmodule

// File: rtl/mux_scan_ctrl.sv
// Mux scan controller: steps a downstream N:1 mux through every input,
// waits DWELL cycles per channel, samples the fed-back output and presents
// the assembled frame with a valid/ready handshake.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int SEL_W = SEL_W_DEF,
  parameter int DWELL = DWELL_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             continuous,
  output logic [SEL_W-1:0] sel,
  input  logic             y_in,
  output logic [N-1:0]     frame_data,
  output logic             frame_valid,
  input  logic             frame_ready,
  output logic             busy,
  output logic [7:0]       frame_cnt
);

  localparam logic [SEL_W-1:0] CH_LAST = SEL_W'(N - 1);
  localparam logic [SEL_W-1:0] CH_ZERO = {SEL_W{1'b0}};
  localparam logic [SEL_W-1:0] CH_ONE  = SEL_W'(1);

  scan_state_e      state_q, state_d;
  logic [SEL_W-1:0] ch_q, ch_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [N-1:0]     shadow_q, shadow_d;
  logic [N-1:0]     frame_data_q, frame_data_d;
  logic             frame_valid_q, frame_valid_d;
  logic             busy_q, busy_d;
  logic [7:0]       frame_cnt_q, frame_cnt_d;
  logic             armed_q, armed_d;

  logic dwell_en;
  logic dwell_clr;
  logic dwell_tc;

  // The counter runs only in SETTLE and restarts at zero for every channel.
  assign dwell_en  = (state_q == ST_SETTLE);
  assign dwell_clr = ~dwell_en | dwell_tc;

  mux_scan_dwell_cnt #(
    .DWELL (DWELL)
  ) u_dwell_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (dwell_clr),
    .en    (dwell_en),
    .tc    (dwell_tc)
  );

  // Next-state, channel, shadow and output computation for the scan FSM.
  always_comb begin
    state_d      = state_q;
    ch_d         = ch_q;
    shadow_d     = shadow_q;
    frame_data_d = frame_data_q;
    frame_cnt_d  = frame_cnt_q;
    // armed goes high one edge after reset so start is never taken on that edge
    armed_d      = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (start && armed_q) begin
          state_d = ST_SETTLE;
          ch_d    = CH_ZERO;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SETTLE: begin
        if (dwell_tc) begin
          state_d = ST_SAMPLE;
        end else begin
          state_d = ST_SETTLE;
        end
      end

      ST_SAMPLE: begin
        shadow_d[ch_q] = y_in;
        if (ch_q == CH_LAST) begin
          // last channel: publish the frame instead of letting ch wrap
          state_d      = ST_OUTPUT;
          frame_data_d = shadow_d;
        end else begin
          state_d = ST_SETTLE;
          ch_d    = ch_q + CH_ONE;
        end
      end

      ST_OUTPUT: begin
        if (frame_ready) begin
          frame_cnt_d = frame_cnt_q + 8'd1;
          ch_d        = CH_ZERO;
          if (continuous) begin
            state_d = ST_SETTLE;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_OUTPUT;
        end
      end

      default: begin
        state_d = ST_IDLE;
        ch_d    = CH_ZERO;
      end
    endcase

    // Outputs are derived from the next state so they are registered with it.
    busy_d        = (state_d != ST_IDLE);
    frame_valid_d = (state_d == ST_OUTPUT);
    if (state_d == ST_IDLE) begin
      sel_d = CH_ZERO;
    end else begin
      sel_d = ch_d;
    end
  end

  // State and registered outputs, all cleared asynchronously on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      ch_q          <= CH_ZERO;
      sel_q         <= CH_ZERO;
      shadow_q      <= {N{1'b0}};
      frame_data_q  <= {N{1'b0}};
      frame_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      frame_cnt_q   <= 8'd0;
      armed_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      ch_q          <= ch_d;
      sel_q         <= sel_d;
      shadow_q      <= shadow_d;
      frame_data_q  <= frame_data_d;
      frame_valid_q <= frame_valid_d;
      busy_q        <= busy_d;
      frame_cnt_q   <= frame_cnt_d;
      armed_q       <= armed_d;
    end
  end

  assign sel         = sel_q;
  assign frame_data  = frame_data_q;
  assign frame_valid = frame_valid_q;
  assign busy        = busy_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: doc/mux_scan_ctrl.md
MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 Parameter N, default 16: number of mux inputs scanned; power of two, 2..256.
REQ-002 Parameter SEL_W, default 4: select width, equal to log2(N).
REQ-003 Parameter DWELL, default 2: settle cycles per channel before sampling; minimum 1, maximum 255.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-005 clk  input  1: single rising-edge clock.
REQ-006 rst_n  input  1: asynchronous active-low reset.
REQ-007 start  input  1: request one scan frame; sampled only in IDLE.
REQ-008 continuous  input  1: when 1, a new frame begins automatically after each accepted frame.
REQ-009 sel  output  SEL_W: select driven to the downstream N:1 mux.
REQ-010 y_in  input  1: mux output fed back for sampling.
REQ-011 frame_data  output  N: assembled frame; bit i holds the y_in value sampled while sel = i.
REQ-012 frame_valid  output  1: frame_data is valid.
REQ-013 frame_ready  input  1: consumer accepts frame_data.
REQ-014 busy  output  1: high in any state other than IDLE.
REQ-015 frame_cnt  output  8: count of accepted frames, wraps 255 to 0.

Function
REQ-016 FSM states: IDLE, SETTLE, SAMPLE, OUTPUT.
REQ-017 IDLE: sel=0, busy=0, frame_valid=0; start=1 at an edge -> SETTLE with ch=0 and dwell counter=0.
REQ-018 SETTLE: sel=ch; dwell counter increments each edge; after DWELL edges in SETTLE -> SAMPLE.
REQ-019 SAMPLE: lasts one edge; at that edge y_in is captured into shadow bit ch. If ch=N-1 -> OUTPUT, else ch increments -> SETTLE with dwell counter cleared.
REQ-020 sel SHALL change only on entry to SETTLE, never in SAMPLE, so y_in has had DWELL full cycles to settle.
REQ-021 Latency: frame_valid rises N*(DWELL+1) edges after the edge that sampled start; this is 48 edges for default parameters.
REQ-022 OUTPUT: frame_valid=1 and frame_data=shadow; both stay stable until the edge where frame_ready=1.
REQ-023 On the accepting edge, frame_cnt increments. If continuous=1, next state is SETTLE with ch=0; otherwise next state is IDLE.
REQ-024 frame_data SHALL retain the last accepted frame after frame_valid falls and SHALL update only on entry to OUTPUT.
REQ-025 start SHALL be ignored outside IDLE; no queuing.
REQ-026 continuous SHALL be sampled only at the accepting edge in OUTPUT; clearing it mid-frame completes the current frame.
REQ-027 frame_ready SHALL be ignored outside OUTPUT.
REQ-028 ch counter is SEL_W bits wide and is never allowed to wrap inside a frame.

Reset
REQ-029 rst_n low SHALL immediately force: state=IDLE, sel=0, frame_data=0, shadow=0, frame_valid=0, busy=0, frame_cnt=0, ch=0, dwell counter=0.
REQ-030 Reset asserted mid-frame SHALL discard the partial frame; no frame_valid is produced for it.
REQ-031 Reset deassertion SHALL be followed by at least one edge in IDLE before start is honoured.

Structure
REQ-032 Shared package mux_scan_pkg SHALL hold the state enumeration type and the default constants N=16, SEL_W=4, DWELL=2.
REQ-033 One sub-module, mux_scan_dwell_cnt, SHALL implement the dwell counter with clear and terminal-count outputs; the FSM, channel counter and shadow register stay in the top level.

Verification (DWELL=2, N=16 unless stated; y_in generated by a 16:1 mux model driven by sel)
REQ-034 Mux inputs 16'hA5C3, single start pulse -> frame_valid rises 48 edges later; frame_data=16'hA5C3; frame_cnt=1; state returns to IDLE.
REQ-035 frame_ready held low for 20 cycles in OUTPUT -> frame_data and frame_valid stay stable; accepted on the first frame_ready=1 edge.
REQ-036 continuous=1, mux inputs changed from 16'h0001 to 16'h8000 between frames -> back-to-back frames 16'h0001 then 16'h8000; no IDLE cycle between them; sel sequence restarts at 0.
REQ-037 rst_n pulsed low at channel 7 -> all outputs cleared asynchronously; no frame_valid; a new start yields a correct full frame.
REQ-038 start pulsed during SETTLE and during OUTPUT -> ignored; exactly one frame is produced.
REQ-039 257 frames accepted with continuous=1 -> frame_cnt wraps from 255 to 0 and reads 1 at the end.
